// File: rtl/ov7670_pixel_packer.sv
// OV7670 capture front end: synchronizes the raw camera bus into clk, packs byte pairs
// into RGB565 words for the pixel queue and reports per-frame geometry/overflow status.
//
// state     | meaning
// IDLE      | capture disabled, waiting for enable
// WAIT_RISE | armed, waiting for vertical blanking to begin
// WAIT_FALL | in vertical blanking, next frame starts when vsync falls
// CAPTURE   | frame active, packing line bytes into pixels
module ov7670_pixel_packer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter bit BYTE_SWAP    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        queue_full,
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_error,
  output logic        overflow,
  output logic [10:0] line_count
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL, CAPTURE} state_t;

  localparam logic [10:0] WIDTH_L  = 11'(FRAME_WIDTH);
  localparam logic [10:0] HEIGHT_L = 11'(FRAME_HEIGHT);
  localparam logic [10:0] CNT_MAX  = 11'h7ff;

  state_t      state, state_n;
  logic [2:0]  pclk_s;
  logic [1:0]  vsync_s, href_s;
  logic [7:0]  data_s1, data_s2;
  logic        vsync_q, href_q;
  logic [7:0]  b0;
  logic [15:0] pix_q;
  logic        push_q;
  logic        phase;
  logic        line_has_byte;
  logic [10:0] pix_cnt, line_cnt;
  logic        err;
  logic        sof_pending;

  logic        pe, vsync_rise, vsync_fall, href_fall;
  logic        line_close, line_err;
  logic [10:0] line_cnt_closed;
  logic        err_closed;
  logic        start_d, done_d;

  assign pe         = pclk_s[1] & ~pclk_s[2];
  assign vsync_rise = vsync_s[1] & ~vsync_q;
  assign vsync_fall = ~vsync_s[1] & vsync_q;
  assign href_fall  = ~href_s[1] & href_q;

  assign queue_wr_en = push_q;
  assign queue_data  = push_q ? {sof_pending, pix_q} : 17'd0;

  // Line bookkeeping is resolved combinationally so a line closing in the same
  // cycle as the frame end is already folded into the frame result.
  always_comb begin
    line_close      = (state == CAPTURE) & href_fall;
    line_err        = line_close & (phase | (pix_cnt != WIDTH_L));
    line_cnt_closed = line_cnt;
    if (line_close && line_has_byte && line_cnt != CNT_MAX)
      line_cnt_closed = line_cnt + 11'd1;
    err_closed      = err | line_err;
  end

  always_comb begin
    state_n = state;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE:      if (enable) state_n = WAIT_RISE;
      WAIT_RISE: if (vsync_rise) state_n = WAIT_FALL;
      WAIT_FALL: begin
        if (vsync_fall) begin
          if (enable) begin
            start_d = 1'b1;
            state_n = CAPTURE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          done_d  = 1'b1;
          state_n = WAIT_FALL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pclk_s        <= '0;
      vsync_s       <= '0;
      href_s        <= '0;
      data_s1       <= '0;
      data_s2       <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      b0            <= '0;
      pix_q         <= '0;
      push_q        <= 1'b0;
      phase         <= 1'b0;
      line_has_byte <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      err           <= 1'b0;
      sof_pending   <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      overflow      <= 1'b0;
      line_count    <= '0;
    end else begin
      pclk_s  <= {pclk_s[1:0], cam_pclk};
      vsync_s <= {vsync_s[0], cam_vsync};
      href_s  <= {href_s[0], cam_href};
      data_s1 <= cam_data;
      data_s2 <= data_s1;
      vsync_q <= vsync_s[1];
      href_q  <= href_s[1];

      state       <= state_n;
      frame_start <= start_d;
      frame_done  <= done_d;
      push_q      <= 1'b0;

      if (done_d) begin
        line_count  <= line_cnt_closed;
        frame_error <= err_closed | (line_cnt_closed != HEIGHT_L);
      end

      // sof stays pending across a dropped push so the first stored pixel carries it
      if (push_q && !queue_full) sof_pending <= 1'b0;
      if (push_q && queue_full)  overflow    <= 1'b1;

      if (start_d) begin
        pix_cnt       <= '0;
        line_cnt      <= '0;
        err           <= 1'b0;
        phase         <= 1'b0;
        line_has_byte <= 1'b0;
        sof_pending   <= 1'b1;
      end else if (state == CAPTURE) begin
        if (line_close) begin
          line_cnt      <= line_cnt_closed;
          err           <= err_closed;
          phase         <= 1'b0;
          pix_cnt       <= '0;
          line_has_byte <= 1'b0;
        end else if (pe && href_s[1]) begin
          line_has_byte <= 1'b1;
          if (line_cnt >= HEIGHT_L) err <= 1'b1;
          if (!phase) begin
            b0    <= data_s2;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 11'd1;
            if (BYTE_SWAP) pix_q <= {data_s2, b0};
            else           pix_q <= {b0, data_s2};
            if (pix_cnt < WIDTH_L && line_cnt < HEIGHT_L) push_q <= 1'b1;
            else                                          err    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// Bench for ov7670_pixel_packer: drives a slow camera bus into two instances (normal and
// byte-swapped) and compares pushed pixels and frame status against a frame-level model.
module tb_ov7670_pixel_packer;

  localparam int TW = 4;
  localparam int TH = 2;

  logic        clk = 1'b0;
  logic        reset, enable, cam_pclk, cam_vsync, cam_href, queue_full;
  logic [7:0]  cam_data;
  logic        wr0, start0, done0, err0, ovf0;
  logic        wr1, start1, done1, err1, ovf1;
  logic [16:0] data0, data1;
  logic [10:0] lc0, lc1;

  int tests = 0;
  int fails = 0;

  logic [16:0] got0[$], got1[$], exp0[$], exp1[$];
  logic [7:0]  byte_buf [0:3][0:15];
  int          line_len [0:3];
  int          done_cnt = 0, start_cnt = 0, coincide_cnt = 0;
  logic        last_err;
  logic [10:0] last_lines;
  int          drop_idx;
  logic        exp_err;
  int          exp_lines;

  ov7670_pixel_packer #(.FRAME_WIDTH(TW), .FRAME_HEIGHT(TH), .BYTE_SWAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .queue_full(queue_full), .queue_wr_en(wr0),
    .queue_data(data0), .frame_start(start0), .frame_done(done0), .frame_error(err0),
    .overflow(ovf0), .line_count(lc0));

  ov7670_pixel_packer #(.FRAME_WIDTH(TW), .FRAME_HEIGHT(TH), .BYTE_SWAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .queue_full(queue_full), .queue_wr_en(wr1),
    .queue_data(data1), .frame_start(start1), .frame_done(done1), .frame_error(err1),
    .overflow(ovf1), .line_count(lc1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr0 && !queue_full) got0.push_back(data0);
      if (wr1 && !queue_full) got1.push_back(data1);
      if (done0) begin
        done_cnt++;
        last_err   = err0;
        last_lines = lc0;
      end
      if (start0) start_cnt++;
      if (start0 && done0) coincide_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_pclk = 1'b0;
    cam_data = b;
    cycles(4);
    cam_pclk = 1'b1;
    cycles(4);
  endtask

  task automatic fill_frame(input int nlines, input int len0, input int len1, input int len2);
    line_len[0] = len0; line_len[1] = len1; line_len[2] = len2; line_len[3] = 0;
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < 16; b++) byte_buf[l][b] = 8'($urandom);
    if (nlines < 3) line_len[2] = 0;
    if (nlines < 2) line_len[1] = 0;
  endtask

  // Frame-level reference: pairs of bytes per line become pixels, clipped to the
  // frame geometry; any deviation from TW x TH or an odd line marks the frame bad.
  task automatic model_frame(input int nlines);
    logic sof;
    int   pix;
    int   n;
    sof = 1'b1; pix = 0;
    exp0.delete(); exp1.delete();
    exp_err = 1'b0; exp_lines = 0;
    for (int l = 0; l < nlines; l++) begin
      n = line_len[l];
      if (n > 0) exp_lines++;
      if (n % 2 != 0) exp_err = 1'b1;
      if (n / 2 != TW) exp_err = 1'b1;
      if (l >= TH && n > 0) exp_err = 1'b1;
      for (int p = 0; p < n / 2; p++) begin
        if (p < TW && l < TH) begin
          if (pix != drop_idx) begin
            exp0.push_back({sof, byte_buf[l][2*p], byte_buf[l][2*p+1]});
            exp1.push_back({sof, byte_buf[l][2*p+1], byte_buf[l][2*p]});
            sof = 1'b0;
          end
          pix++;
        end
      end
    end
    if (exp_lines != TH) exp_err = 1'b1;
  endtask

  task automatic run_frame(input int nlines, input bit simul, input bit full_first, input int dis_after);
    if (!cam_vsync) begin
      cam_vsync = 1'b1;
      cycles(12);
    end
    cam_vsync = 1'b0;
    cycles(12);
    for (int l = 0; l < nlines; l++) begin
      cam_href = 1'b1;
      cycles(2);
      for (int b = 0; b < line_len[l]; b++) begin
        if (full_first && l == 0 && b == 0) queue_full = 1'b1;
        cam_byte(byte_buf[l][b]);
        if (full_first && l == 0 && b == 1) queue_full = 1'b0;
      end
      cam_pclk = 1'b0;
      cycles(2);
      cam_href = 1'b0;
      if (simul && l == nlines - 1) cam_vsync = 1'b1;
      else cycles(10);
      if (l == dis_after) enable = 1'b0;
    end
    cam_vsync = 1'b1;
    cycles(20);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    cam_data = 8'h00; queue_full = 1'b0; drop_idx = -1;
    cycles(4);
    tests++; if (wr0 !== 1'b0)        begin fails++; $display("FAIL reset_wr_en got %b exp 0", wr0); end
    tests++; if (data0 !== 17'd0)     begin fails++; $display("FAIL reset_data got %h exp 0", data0); end
    tests++; if (start0 !== 1'b0)     begin fails++; $display("FAIL reset_frame_start got %b exp 0", start0); end
    tests++; if (done0 !== 1'b0)      begin fails++; $display("FAIL reset_frame_done got %b exp 0", done0); end
    tests++; if (err0 !== 1'b0)       begin fails++; $display("FAIL reset_frame_error got %b exp 0", err0); end
    tests++; if (ovf0 !== 1'b0)       begin fails++; $display("FAIL reset_overflow got %b exp 0", ovf0); end
    tests++; if (lc0 !== 11'd0)       begin fails++; $display("FAIL reset_line_count got %0d exp 0", lc0); end
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_clean_frame;
    int g0, g1, d, s;
    g0 = got0.size(); g1 = got1.size(); d = done_cnt; s = start_cnt;
    enable = 1'b1;
    fill_frame(2, 8, 8, 0);
    byte_buf[0][0] = 8'hF8; byte_buf[0][1] = 8'h00; byte_buf[0][2] = 8'h07; byte_buf[0][3] = 8'hE0;
    drop_idx = -1;
    model_frame(2);
    run_frame(2, 1'b0, 1'b0, -1);
    tests++; if (got0.size() - g0 != 8) begin fails++; $display("FAIL clean_count got %0d exp 8", got0.size() - g0); end
    tests++; if (got0[g0] !== 17'h1F800) begin fails++; $display("FAIL clean_first got %h exp 1f800", got0[g0]); end
    tests++; if (got0[g0+1] !== 17'h007E0) begin fails++; $display("FAIL clean_second got %h exp 007e0", got0[g0+1]); end
    for (int i = 0; i < exp0.size(); i++) begin
      tests++; if (got0[g0+i] !== exp0[i]) begin fails++; $display("FAIL clean_pix%0d got %h exp %h", i, got0[g0+i], exp0[i]); end
      tests++; if (got1[g1+i] !== exp1[i]) begin fails++; $display("FAIL clean_swap_pix%0d got %h exp %h", i, got1[g1+i], exp1[i]); end
    end
    tests++; if (done_cnt - d != 1)  begin fails++; $display("FAIL clean_done got %0d exp 1", done_cnt - d); end
    tests++; if (start_cnt - s != 1) begin fails++; $display("FAIL clean_start got %0d exp 1", start_cnt - s); end
    tests++; if (last_err !== 1'b0)  begin fails++; $display("FAIL clean_error got %b exp 0", last_err); end
    tests++; if (last_lines !== 11'd2) begin fails++; $display("FAIL clean_lines got %0d exp 2", last_lines); end
  endtask

  task automatic test_byte_swap;
    int g0, g1;
    g0 = got0.size(); g1 = got1.size();
    fill_frame(2, 8, 8, 0);
    byte_buf[0][0] = 8'h34; byte_buf[0][1] = 8'h12;
    drop_idx = -1;
    run_frame(2, 1'b0, 1'b0, -1);
    tests++; if (got1[g1][15:0] !== 16'h1234) begin fails++; $display("FAIL swap_pix got %h exp 1234", got1[g1][15:0]); end
    tests++; if (got0[g0][15:0] !== 16'h3412) begin fails++; $display("FAIL noswap_pix got %h exp 3412", got0[g0][15:0]); end
    tests++; if (got1[g1][16] !== 1'b1)       begin fails++; $display("FAIL swap_sof got %b exp 1", got1[g1][16]); end
  endtask

  task automatic test_random_frames;
    int g0, g1, d, nl;
    int ln [0:2];
    for (int f = 0; f < 6; f++) begin
      g0 = got0.size(); g1 = got1.size(); d = done_cnt;
      nl = $urandom_range(1, 3);
      for (int l = 0; l < 3; l++) ln[l] = ($urandom_range(0, 1) == 1) ? 8 : $urandom_range(1, 12);
      fill_frame(nl, ln[0], ln[1], ln[2]);
      drop_idx = -1;
      model_frame(nl);
      run_frame(nl, 1'b0, 1'b0, -1);
      tests++; if (got0.size() - g0 != exp0.size()) begin fails++; $display("FAIL rand%0d_count got %0d exp %0d", f, got0.size() - g0, exp0.size()); end
      tests++; if (got1.size() - g1 != exp1.size()) begin fails++; $display("FAIL rand%0d_swap_count got %0d exp %0d", f, got1.size() - g1, exp1.size()); end
      for (int i = 0; i < exp0.size(); i++) begin
        tests++; if (got0[g0+i] !== exp0[i]) begin fails++; $display("FAIL rand%0d_pix%0d got %h exp %h", f, i, got0[g0+i], exp0[i]); end
        tests++; if (got1[g1+i] !== exp1[i]) begin fails++; $display("FAIL rand%0d_swap_pix%0d got %h exp %h", f, i, got1[g1+i], exp1[i]); end
      end
      tests++; if (done_cnt - d != 1) begin fails++; $display("FAIL rand%0d_done got %0d exp 1", f, done_cnt - d); end
      tests++; if (last_err !== exp_err) begin fails++; $display("FAIL rand%0d_error got %b exp %b", f, last_err, exp_err); end
      tests++; if (last_lines !== 11'(exp_lines)) begin fails++; $display("FAIL rand%0d_lines got %0d exp %0d", f, last_lines, exp_lines); end
    end
  endtask

  task automatic test_overflow;
    int g0;
    g0 = got0.size();
    tests++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL ovf_before got %b exp 0", ovf0); end
    fill_frame(2, 8, 8, 0);
    drop_idx = 0;
    model_frame(2);
    run_frame(2, 1'b0, 1'b1, -1);
    drop_idx = -1;
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", ovf0); end
    tests++; if (got0.size() - g0 != 7) begin fails++; $display("FAIL ovf_count got %0d exp 7", got0.size() - g0); end
    tests++; if (got0[g0][16] !== 1'b1) begin fails++; $display("FAIL ovf_sof got %b exp 1", got0[g0][16]); end
    for (int i = 0; i < exp0.size(); i++) begin
      tests++; if (got0[g0+i] !== exp0[i]) begin fails++; $display("FAIL ovf_pix%0d got %h exp %h", i, got0[g0+i], exp0[i]); end
    end
    tests++; if (last_err !== 1'b0) begin fails++; $display("FAIL ovf_error got %b exp 0", last_err); end
  endtask

  task automatic test_odd_line;
    int g0;
    g0 = got0.size();
    fill_frame(2, 7, 8, 0);
    model_frame(2);
    run_frame(2, 1'b0, 1'b0, -1);
    tests++; if (got0.size() - g0 != 7) begin fails++; $display("FAIL odd_count got %0d exp 7", got0.size() - g0); end
    for (int i = 0; i < exp0.size(); i++) begin
      tests++; if (got0[g0+i] !== exp0[i]) begin fails++; $display("FAIL odd_pix%0d got %h exp %h", i, got0[g0+i], exp0[i]); end
    end
    tests++; if (last_err !== 1'b1) begin fails++; $display("FAIL odd_error got %b exp 1", last_err); end
    tests++; if (last_lines !== 11'd2) begin fails++; $display("FAIL odd_lines got %0d exp 2", last_lines); end
  endtask

  task automatic test_short_frame;
    int g0;
    g0 = got0.size();
    fill_frame(1, 8, 0, 0);
    run_frame(1, 1'b0, 1'b0, -1);
    tests++; if (got0.size() - g0 != 4) begin fails++; $display("FAIL short_count got %0d exp 4", got0.size() - g0); end
    tests++; if (last_err !== 1'b1) begin fails++; $display("FAIL short_error got %b exp 1", last_err); end
    tests++; if (last_lines !== 11'd1) begin fails++; $display("FAIL short_lines got %0d exp 1", last_lines); end
  endtask

  task automatic test_simultaneous;
    int g0, d;
    g0 = got0.size(); d = done_cnt;
    fill_frame(2, 8, 8, 0);
    model_frame(2);
    run_frame(2, 1'b1, 1'b0, -1);
    tests++; if (got0.size() - g0 != 8) begin fails++; $display("FAIL simul_count got %0d exp 8", got0.size() - g0); end
    tests++; if (done_cnt - d != 1) begin fails++; $display("FAIL simul_done got %0d exp 1", done_cnt - d); end
    tests++; if (last_lines !== 11'd2) begin fails++; $display("FAIL simul_lines got %0d exp 2", last_lines); end
    tests++; if (last_err !== 1'b0) begin fails++; $display("FAIL simul_error got %b exp 0", last_err); end
  endtask

  task automatic test_enable_drop;
    int g0, d, s;
    g0 = got0.size(); d = done_cnt; s = start_cnt;
    fill_frame(2, 8, 8, 0);
    run_frame(2, 1'b0, 1'b0, 0);
    tests++; if (done_cnt - d != 1) begin fails++; $display("FAIL en_done got %0d exp 1", done_cnt - d); end
    tests++; if (last_err !== 1'b0) begin fails++; $display("FAIL en_error got %b exp 0", last_err); end
    tests++; if (last_lines !== 11'd2) begin fails++; $display("FAIL en_lines got %0d exp 2", last_lines); end
    cam_vsync = 1'b0; cycles(12);
    cam_vsync = 1'b1; cycles(12);
    cam_vsync = 1'b0; cycles(12);
    cam_href = 1'b1; cycles(2);
    for (int b = 0; b < 8; b++) cam_byte(8'($urandom));
    cam_pclk = 1'b0; cycles(2);
    cam_href = 1'b0; cycles(10);
    tests++; if (start_cnt - s != 1) begin fails++; $display("FAIL en_no_start got %0d exp 1", start_cnt - s); end
    tests++; if (got0.size() - g0 != 8) begin fails++; $display("FAIL en_pushes got %0d exp 8", got0.size() - g0); end
    tests++; if (coincide_cnt != 0) begin fails++; $display("FAIL start_done_overlap got %0d exp 0", coincide_cnt); end
    enable = 1'b1;
    cycles(4);
  endtask

  task automatic test_reset_midline;
    int g0, d;
    d = done_cnt;
    fill_frame(2, 8, 8, 0);
    run_frame(1, 1'b0, 1'b0, -1);
    cam_vsync = 1'b0; cycles(12);
    cam_href = 1'b1; cycles(2);
    for (int b = 0; b < 3; b++) cam_byte(8'($urandom));
    cam_pclk = 1'b0;
    reset = 1'b1;
    cycles(1);
    tests++; if (wr0 !== 1'b0)    begin fails++; $display("FAIL rst_mid_wr_en got %b exp 0", wr0); end
    tests++; if (data0 !== 17'd0) begin fails++; $display("FAIL rst_mid_data got %h exp 0", data0); end
    tests++; if (err0 !== 1'b0)   begin fails++; $display("FAIL rst_mid_error got %b exp 0", err0); end
    tests++; if (ovf0 !== 1'b0)   begin fails++; $display("FAIL rst_mid_overflow got %b exp 0", ovf0); end
    tests++; if (lc0 !== 11'd0)   begin fails++; $display("FAIL rst_mid_lines got %0d exp 0", lc0); end
    tests++; if (done0 !== 1'b0 || start0 !== 1'b0) begin fails++; $display("FAIL rst_mid_pulses got %b%b exp 00", done0, start0); end
    cycles(5);
    d = done_cnt;
    reset = 1'b0;
    for (int b = 0; b < 5; b++) cam_byte(8'($urandom));
    cam_pclk = 1'b0; cycles(2);
    cam_href = 1'b0; cycles(10);
    cam_vsync = 1'b1; cycles(20);
    tests++; if (done_cnt - d != 0) begin fails++; $display("FAIL rst_mid_no_done got %0d exp 0", done_cnt - d); end
    g0 = got0.size(); d = done_cnt;
    fill_frame(2, 8, 8, 0);
    drop_idx = -1;
    model_frame(2);
    run_frame(2, 1'b0, 1'b0, -1);
    tests++; if (got0.size() - g0 != 8) begin fails++; $display("FAIL rst_after_count got %0d exp 8", got0.size() - g0); end
    for (int i = 0; i < exp0.size(); i++) begin
      tests++; if (got0[g0+i] !== exp0[i]) begin fails++; $display("FAIL rst_after_pix%0d got %h exp %h", i, got0[g0+i], exp0[i]); end
    end
    tests++; if (done_cnt - d != 1) begin fails++; $display("FAIL rst_after_done got %0d exp 1", done_cnt - d); end
    tests++; if (last_err !== 1'b0) begin fails++; $display("FAIL rst_after_error got %b exp 0", last_err); end
    tests++; if (last_lines !== 11'd2) begin fails++; $display("FAIL rst_after_lines got %0d exp 2", last_lines); end
  endtask

  initial begin
    test_reset;
    test_clean_frame;
    test_byte_swap;
    test_random_frames;
    test_overflow;
    test_odd_line;
    test_short_frame;
    test_simultaneous;
    test_enable_drop;
    test_reset_midline;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
